// File: rtl/memory_stage.sv
// Beta CPU memory stage: latches execute results, runs LD/LDR/ST over a
// req/ack data port with stall, and injects an exception IR on misaligned
// access or bus timeout.

`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h77DF_0000
`endif
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif

module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ir_src_mem,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] y,
    input  logic [31:0] d,
    output logic        stall_mem,
    output logic        mem_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_next,
    output logic [31:0] ir_next,
    output logic [31:0] wb_data_next
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_LDR = 6'b011111;
    localparam logic [5:0] OP_ST  = 6'b011001;

    typedef enum logic [0:0] {StIdle, StAccess} state_t;

    logic [31:0]   pc_mem, ir_mem, y_mem, d_mem;
    state_t        state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;

    logic is_rd, is_wr, is_mem, misaligned, timeout, fault;
    logic nxt_is_mem, nxt_go;

    // Decode the op held in the stage and the op about to be loaded.
    always_comb begin
        is_rd      = (ir_mem[31:26] == OP_LD) || (ir_mem[31:26] == OP_LDR);
        is_wr      = (ir_mem[31:26] == OP_ST);
        is_mem     = is_rd || is_wr;
        misaligned = is_mem && (y_mem[1:0] != 2'b00);
        nxt_is_mem = (ir[31:26] == OP_LD) || (ir[31:26] == OP_LDR) || (ir[31:26] == OP_ST);
        nxt_go     = nxt_is_mem && (y[1:0] == 2'b00);
        timeout    = (TIMEOUT_CYCLES != 0) && (counter_q == CNT_LAST);
    end

    // Bus handshake, stall and fault generation.
    always_comb begin
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        stall_mem = 1'b0;
        fault     = 1'b0;
        if (state_q == StAccess) begin
            dmem_req  = 1'b1;
            dmem_we   = is_wr;
            stall_mem = !dmem_ack && !timeout;
            fault     = !dmem_ack && timeout;
        end else begin
            // Misaligned ops never reach ACCESS; they fault straight from IDLE.
            fault = misaligned;
        end
        mem_fault  = fault;
        dmem_addr  = {y_mem[31:2], 2'b00};
        dmem_wdata = d_mem;
    end

    // Values forwarded to writeback.
    always_comb begin
        pc_next      = pc_mem;
        wb_data_next = (state_q == StAccess && dmem_ack && is_rd) ? dmem_rdata : y_mem;
        if (stall_mem) begin
            ir_next = `INST_NOP;
        end else if (fault) begin
            ir_next = `INST_BNE_EXCEPT;
        end else begin
            unique case (ir_src_mem)
                `IR_SRC_EXCEPT: ir_next = `INST_BNE_EXCEPT;
                `IR_SRC_NOP:    ir_next = `INST_NOP;
                `IR_SRC_DATA:   ir_next = ir_mem;
                default:        ir_next = 'x;
            endcase
        end
    end

    // Next state: an aligned memory op loaded on a free edge starts ACCESS at once.
    always_comb begin
        state_d   = state_q;
        counter_d = '0;
        unique case (state_q)
            StIdle: begin
                state_d = nxt_go ? StAccess : StIdle;
            end
            StAccess: begin
                if (dmem_ack) begin
                    state_d = nxt_go ? StAccess : StIdle;
                end else if (timeout) begin
                    state_d = StIdle;
                end else begin
                    // Saturation only matters when the timeout is disabled.
                    counter_d = (counter_q == CNT_MAX) ? counter_q : counter_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage registers: load when not stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_mem <= '0;
            ir_mem <= `INST_NOP;
            y_mem  <= '0;
            d_mem  <= '0;
        end else if (!stall_mem) begin
            pc_mem <= pc;
            ir_mem <= ir;
            y_mem  <= y;
            d_mem  <= d;
        end
    end

    // Access FSM state and timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a scoreboard of expected per-cycle outputs.

`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h77DF_0000
`endif
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif

module tb_memory_stage;

    localparam logic [31:0] NOP   = `INST_NOP;
    localparam logic [31:0] BNE   = `INST_BNE_EXCEPT;
    localparam logic [31:0] I_ADD = 32'h8022_1800;
    localparam logic [31:0] I_LD  = 32'h6022_0000;
    localparam logic [31:0] I_ST  = 32'h6422_0000;
    localparam logic [31:0] I_LDR = 32'h7C22_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ir_src_mem;
    logic [31:0] pc, ir, y, d;
    logic        stall_mem, mem_fault, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_next, ir_next, wb_data_next;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_src_mem   (ir_src_mem),
        .pc           (pc),
        .ir           (ir),
        .y            (y),
        .d            (d),
        .stall_mem    (stall_mem),
        .mem_fault    (mem_fault),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .pc_next      (pc_next),
        .ir_next      (ir_next),
        .wb_data_next (wb_data_next)
    );

    typedef struct {
        string       tag;
        logic        req;
        logic        stall;
        logic        fault;
        logic [31:0] pcn;
        logic [31:0] irn;
        bit          ck_wb;
        logic [31:0] wb;
        bit          ck_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic req, input logic stall,
                        input logic fault, input logic [31:0] pcn, input logic [31:0] irn,
                        input bit ck_wb, input logic [31:0] wb, input bit ck_mem,
                        input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.tag = tag; e.req = req; e.stall = stall; e.fault = fault;
        e.pcn = pcn; e.irn = irn; e.ck_wb = ck_wb; e.wb = wb;
        e.ck_mem = ck_mem; e.we = we; e.addr = addr; e.wdata = wdata;
        sb.push_back(e);
    endtask

    task automatic setin(input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] yy, input logic [31:0] dd);
        pc = p; ir = i; y = yy; d = dd;
    endtask

    // Compare mid-cycle, then advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".req"},   32'(dmem_req),  32'(e.req));
            chk({e.tag, ".stall"}, 32'(stall_mem), 32'(e.stall));
            chk({e.tag, ".fault"}, 32'(mem_fault), 32'(e.fault));
            chk({e.tag, ".pc"},    pc_next,        e.pcn);
            chk({e.tag, ".ir"},    ir_next,        e.irn);
            if (e.ck_wb) chk({e.tag, ".wb"}, wb_data_next, e.wb);
            if (e.ck_mem) begin
                chk({e.tag, ".we"},    32'(dmem_we), 32'(e.we));
                chk({e.tag, ".addr"},  dmem_addr,    e.addr);
                chk({e.tag, ".wdata"}, dmem_wdata,   e.wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random data inputs.
        rst_n      = 1'b0;
        ir_src_mem = `IR_SRC_DATA;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        setin($urandom, $urandom, $urandom, $urandom);
        @(posedge clk);
        #1;
        push("rst1", 0, 0, 0, 32'h0, NOP, 1, 32'h0, 0, 0, 0, 0);
        setin($urandom, $urandom, $urandom, $urandom);
        tick();
        rst_n = 1'b1;
        setin(32'h100, I_ADD, 32'h0000_1234, 32'h0);
        push("rst2", 0, 0, 0, 32'h0, NOP, 1, 32'h0, 0, 0, 0, 0);
        tick();

        // ADD passes through; LD follows.
        setin(32'h104, I_LD, 32'h100, 32'h0);
        push("add", 0, 0, 0, 32'h100, I_ADD, 1, 32'h1234, 0, 0, 0, 0);
        tick();

        // LD acked on 3rd request cycle; ST queued behind it.
        setin(32'h108, I_ST, 32'h204, 32'h0000_CAFE);
        push("ld_w1", 1, 1, 0, 32'h104, NOP, 0, 0, 1, 0, 32'h100, 32'h0);
        tick();
        push("ld_w2", 1, 1, 0, 32'h104, NOP, 0, 0, 1, 0, 32'h100, 32'h0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        push("ld_ack", 1, 0, 0, 32'h104, I_LD, 1, 32'hDEAD_BEEF, 1, 0, 32'h100, 32'h0);
        tick();

        // ST zero-wait, back-to-back LD.
        setin(32'h10C, I_LD, 32'h300, 32'h0);
        push("st", 1, 0, 0, 32'h108, I_ST, 1, 32'h204, 1, 1, 32'h204, 32'h0000_CAFE);
        tick();
        setin(32'h200, I_LD, 32'h400, 32'h0);
        dmem_rdata = 32'h1111_2222;
        push("ld_b2b", 1, 0, 0, 32'h10C, I_LD, 1, 32'h1111_2222, 1, 0, 32'h300, 32'h0);
        tick();

        // LD never acked: 15 stall cycles then timeout fault.
        dmem_ack = 1'b0;
        setin(32'h204, NOP, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            push("to_wait", 1, 1, 0, 32'h200, NOP, 0, 0, 1, 0, 32'h400, 32'h0);
            tick();
        end
        push("to_fault", 1, 0, 1, 32'h200, BNE, 0, 0, 1, 0, 32'h400, 32'h0);
        tick();
        setin(32'h300, I_LD, 32'h500, 32'h0);
        push("to_idle", 0, 0, 0, 32'h204, NOP, 0, 0, 0, 0, 0, 0);
        tick();

        // Ack exactly on the timeout cycle: ack wins.
        for (int i = 0; i < 15; i++) begin
            push("ack16_wait", 1, 1, 0, 32'h300, NOP, 0, 0, 1, 0, 32'h500, 32'h0);
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5A5A_5A5A;
        setin(32'h400, I_LD, 32'h102, 32'h0);
        push("ack16", 1, 0, 0, 32'h300, I_LD, 1, 32'h5A5A_5A5A, 1, 0, 32'h500, 32'h0);
        tick();

        // Misaligned LD faults immediately with no request.
        dmem_ack = 1'b0;
        setin(32'h500, I_LD, 32'h600, 32'h0);
        push("misalign", 0, 0, 1, 32'h400, BNE, 1, 32'h102, 0, 0, 0, 0);
        tick();

        // Reset during the 2nd cycle of a pending LD abandons it.
        setin(32'h504, I_ADD, 32'h0, 32'h0);
        push("rst_mid1", 1, 1, 0, 32'h500, NOP, 0, 0, 1, 0, 32'h600, 32'h0);
        tick();
        rst_n = 1'b0;
        push("rst_mid2", 1, 1, 0, 32'h500, NOP, 0, 0, 1, 0, 32'h600, 32'h0);
        tick();
        rst_n = 1'b1;
        setin(32'h600, I_ADD, 32'h77, 32'h0);
        push("rst_after", 0, 0, 0, 32'h0, NOP, 1, 32'h0, 0, 0, 0, 0);
        tick();

        // ir_src_mem selection on a non-memory op.
        ir_src_mem = `IR_SRC_NOP;
        setin(32'h604, I_ADD, 32'h88, 32'h0);
        push("src_nop", 0, 0, 0, 32'h600, NOP, 1, 32'h77, 0, 0, 0, 0);
        tick();
        ir_src_mem = `IR_SRC_EXCEPT;
        setin(32'h700, I_LDR, 32'h800, 32'h0);
        push("src_exc", 0, 0, 0, 32'h604, BNE, 1, 32'h88, 0, 0, 0, 0);
        tick();

        // LDR zero-wait read.
        ir_src_mem = `IR_SRC_DATA;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        setin(32'h704, NOP, 32'h0, 32'h0);
        push("ldr", 1, 0, 0, 32'h700, I_LDR, 1, 32'h0BAD_F00D, 1, 0, 32'h800, 32'h0);
        tick();
        dmem_ack = 1'b0;
        push("final_idle", 0, 0, 0, 32'h704, NOP, 1, 32'h0, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage in the Beta CPU.
- Latches pc, ir, y (ALU result/address) and d (store data) from execute.
- Performs LD, LDR and ST accesses over a req/ack data-memory port, holding the pipeline with a stall until each access completes.
- Forwards pc, ir and the writeback value (load data or ALU result) to writeback, and raises a fault with exception-IR injection on a misaligned address or a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles without ack before a fault; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- ir_src_mem  input  2  IR source select for ir_next (`IR_SRC_EXCEPT / `IR_SRC_NOP / `IR_SRC_DATA)
- pc  input  32  next pc value for this stage (from execute pc_next)
- ir  input  32  next ir value for this stage (from execute ir_next)
- y  input  32  next ALU result for this stage (from execute y_next)
- d  input  32  next store data for this stage (from execute d_next)
- stall_mem  output  1  high = upstream stages and this stage's registers hold
- mem_fault  output  1  one-cycle pulse on misaligned access or timeout
- dmem_req  output  1  data memory request
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  32  word address, {y_mem[31:2],2'b00}
- dmem_wdata  output  32  store data (d_mem)
- dmem_ack  input  1  access complete this cycle
- dmem_rdata  input  32  read data, valid when dmem_ack=1
- pc_next  output  32  pc value for writeback
- ir_next  output  32  ir value for writeback
- wb_data_next  output  32  writeback value

Behaviour:
- Clock is clk; reset rst_n is synchronous and active-low (fixed for this block).
- Stage registers pc_mem, ir_mem, y_mem, d_mem load on posedge clk when stall_mem=0 and hold when stall_mem=1.
- Reset values:
  - ir_mem=`INST_NOP; pc_mem, y_mem, d_mem=0.
  - state=IDLE; counter=0.
  - Hence dmem_req=0, stall_mem=0, mem_fault=0, ir_next=`INST_NOP.
- Decode from ir_mem[31:26]:
  - LD 011000 and LDR 011111 are reads.
  - ST 011001 is a write.
  - All other opcodes are non-memory.
- Misaligned address:
  - Condition: memory op with y_mem[1:0]!=0.
  - No request is issued; mem_fault=1 that cycle; stall_mem=0.
  - ir_next=`INST_BNE_EXCEPT; pc_next=pc_mem.
- FSM states:
  - IDLE.
  - ACCESS: entered on the same edge that loads an aligned memory op into the stage registers.
- IDLE:
  - dmem_req=0, stall_mem=0.
  - wb_data_next=y_mem.
- ACCESS outputs:
  - dmem_req=1; dmem_we=(ST); dmem_addr and dmem_wdata driven from the stage registers, stable until ack.
  - Counter increments each cycle without ack.
  - stall_mem = !dmem_ack && !timeout, where timeout = (TIMEOUT_CYCLES!=0 && counter==TIMEOUT_CYCLES-1).
- ACCESS transitions:
  - On ack: counter cleared. Reads drive wb_data_next=dmem_rdata combinationally that cycle; writes drive wb_data_next=y_mem. The next state is ACCESS if the newly loaded op is an aligned memory op, else IDLE. Zero-wait ack therefore gives no stall, and back-to-back accesses have no idle gap.
  - On timeout without ack: dmem_req stays 1 that final cycle; mem_fault=1; ir_next=`INST_BNE_EXCEPT; stall released; state goes to IDLE.
  - Ack and timeout in the same cycle: ack wins, no fault.
- Accesses are never withdrawn: once ACCESS is entered, req stays high until ack or timeout.
- ir_next priority:
  1. stall_mem=1 → `INST_NOP (bubble to writeback).
  2. Fault → `INST_BNE_EXCEPT.
  3. Otherwise, by ir_src_mem: EXCEPT → `INST_BNE_EXCEPT; NOP → `INST_NOP; DATA → ir_mem; other codes → x.
- ir_src_mem never cancels or starts an access. Squashing is done upstream by NOP injection.
- pc_next=pc_mem at all times.
- Reset mid-ACCESS: the next cycle returns to IDLE with dmem_req=0; the access is abandoned.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; no wrap is possible while TIMEOUT_CYCLES>0. With TIMEOUT_CYCLES=0 the counter saturates.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs → dmem_req=0, stall_mem=0, mem_fault=0, ir_next=`INST_NOP.
- ADD, y=0x00001234 → no dmem_req; wb_data_next=0x00001234, ir_next=ir, stall_mem=0 in the cycle after the load.
- LD, y=0x100, ack on the 3rd request cycle with rdata=0xDEADBEEF:
  - dmem_req=1, dmem_we=0, dmem_addr=0x100 for 3 cycles.
  - stall_mem=1 for 2 cycles with ir_next=`INST_NOP.
  - On the ack cycle: wb_data_next=0xDEADBEEF, stall_mem=0.
- ST, y=0x204, d=0x0000CAFE, ack in the first cycle → one cycle of req=1, we=1, wdata=0xCAFE; no stall. Then a back-to-back LD issues req the next cycle.
- LD never acked, TIMEOUT_CYCLES=16:
  - req high 16 cycles, stall_mem high 15 cycles.
  - Cycle 16: mem_fault=1, ir_next=`INST_BNE_EXCEPT, pc_next=faulting pc.
  - Also cover ack exactly on cycle 16 → no fault.
- LD, y=0x102 → no req, mem_fault=1 immediately, ir_next=`INST_BNE_EXCEPT. Also drive rst_n=0 during the 2nd cycle of a pending LD → req=0 next cycle, state IDLE.
